// File: rtl/bcd_convert_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Accepts a binary value on start, runs WIDTH shift cycles plus one finish
// cycle, then publishes the decimal digits with a one-cycle done pulse.
// bcd_out holds the last completed result until the next conversion ends.
module bcd_convert_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = 4 * DIGITS;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    // Add 3 to every digit that is 5 or more; digits never carry into each other.
    function automatic logic [SW-1:0] adjust_digits(input logic [SW-1:0] s);
        logic [SW-1:0] r;
        r = s;
        for (int i = 0; i < DIGITS; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = s[4*i +: 4];
            end
        end
        return r;
    endfunction

    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] bin_q,     bin_d;
    logic [SW-1:0]    scratch_q, scratch_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic [SW-1:0]    bcd_q,     bcd_d;
    logic [SW-1:0]    scratch_adj_s;

    // Next-state logic: handshake, shift-and-add-3 step and result publication.
    always_comb begin
        state_d       = state_q;
        bin_d         = bin_q;
        scratch_d     = scratch_q;
        cnt_d         = cnt_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        bcd_d         = bcd_q;
        scratch_adj_s = adjust_digits(scratch_q);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bin_d     = bin_in;
                    scratch_d = {SW{1'b0}};
                    cnt_d     = CW'(WIDTH);
                    busy_d    = 1'b1;
                    state_d   = ST_SHIFT;
                end else begin
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // Binary MSB enters the scratch LSB after the digit correction.
                scratch_d = (scratch_adj_s << 1) | {{(SW-1){1'b0}}, bin_q[WIDTH-1]};
                bin_d     = bin_q << 1;
                cnt_d     = cnt_q - CW'(1);
                busy_d    = 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_FINISH: begin
                bcd_d   = scratch_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset discards any partial result.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            bin_q     <= {WIDTH{1'b0}};
            scratch_q <= {SW{1'b0}};
            cnt_q     <= {CW{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= {SW{1'b0}};
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_q;

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Self-checking bench for bcd_convert_seq (WIDTH=8, DIGITS=3).
// Expected digits come from decimal division of the input value.
module tb_bcd_convert_seq;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [7:0]  bin_in;
    logic        busy;
    logic        done;
    logic [11:0] bcd_out;

    int errors = 0;
    int checks = 0;

    bcd_convert_seq #(.WIDTH(8), .DIGITS(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_bcd(input int v);
        return ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept v, optionally poke start/bin_in at cycle poke_at while busy,
    // and return while sampling the done cycle.
    task automatic convert(input logic [7:0] v, input int poke_at, input logic [7:0] poke_val);
        logic [11:0] prev;
        int lat;
        int busy_cnt;
        prev  = bcd_out;
        start = 1'b1;
        bin_in = v;
        tick();
        start  = 1'b0;
        bin_in = 8'($urandom);
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            check("hold_while_busy", 32'(bcd_out), 32'(prev));
            if (lat == poke_at) begin
                start  = 1'b1;
                bin_in = poke_val;
            end else begin
                start  = 1'b0;
                bin_in = 8'($urandom);
            end
            tick();
            lat++;
        end
        start = 1'b0;
        check("latency", 32'(lat), 32'd9);
        check("busy_cycles", 32'(busy_cnt), 32'd9);
        check("busy_in_done", 32'(busy), 32'd0);
        check("result", 32'(bcd_out), ref_bcd(int'(v)));
    endtask

    // One idle cycle after a done: pulse must have dropped.
    task automatic check_done_drop();
        tick();
        check("done_width", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int vals[6];
        logic saw_done;
        logic early;
        logic [7:0] rv;

        reset_n = 1'b0;
        start   = 1'b0;
        bin_in  = 8'd0;
        tick();
        tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_bcd", 32'(bcd_out), 32'd0);
        reset_n = 1'b1;
        tick();

        // Full-scale value.
        convert(8'd255, -1, 8'd0);
        check_done_drop();

        // Directed digit boundaries.
        vals = '{0, 9, 10, 99, 100, 128};
        foreach (vals[i]) begin
            convert(8'(vals[i]), -1, 8'd0);
            check_done_drop();
        end

        // Start while busy is ignored and not queued.
        convert(8'd200, 3, 8'd7);
        saw_done = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        check("ignored_start_no_done", 32'(saw_done), 32'd0);
        check("ignored_start_result", 32'(bcd_out), 32'h200);

        // Reset mid-conversion discards the partial result.
        start  = 1'b1;
        bin_in = 8'd173;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        reset_n = 1'b0;
        tick();
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_bcd", 32'(bcd_out), 32'd0);
        reset_n = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        check("midreset_no_done", 32'(saw_done), 32'd0);
        check("midreset_idle", 32'(busy), 32'd0);

        // Back-to-back: start in the done cycle is accepted immediately.
        convert(8'd42, -1, 8'd0);
        convert(8'd250, -1, 8'd0);
        check_done_drop();

        // Random conversions with random noise on bin_in while busy.
        for (int k = 0; k < 20; k++) begin
            rv = 8'($urandom_range(0, 255));
            convert(rv, int'($urandom_range(0, 12)), 8'($urandom));
            check_done_drop();
        end

        // Sweep with start tied high: one result every 10 cycles.
        start = 1'b1;
        early = 1'b0;
        for (int v = 0; v < 256; v++) begin
            bin_in = 8'(v);
            tick();
            bin_in = 8'($urandom);
            for (int k = 0; k < 8; k++) begin
                tick();
                if (done) early = 1'b1;
            end
            tick();
            check("sweep_done", 32'(done), 32'd1);
            check("sweep_result", 32'(bcd_out), ref_bcd(v));
        end
        start = 1'b0;
        check("sweep_no_early_done", 32'(early), 32'd0);
        check_done_drop();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_convert_seq.md
Name: bcd_convert_seq

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock. It sits downstream of the 8-bit ALU result register and converts the registered result to decimal digits for the HEX displays. It uses a start/busy/done handshake and holds the last result until the next conversion completes.

Parameters:
WIDTH, 8, width of binary input
DIGITS, 3, number of BCD digits produced; must satisfy 10^DIGITS > 2^WIDTH-1 (no overflow detection)

Ports:
clk  input  1  clock; all state changes on rising edge
reset_n  input  1  synchronous active-low reset
start  input  1  request conversion; sampled only in IDLE
bin_in  input  WIDTH  binary value; latched on the accepting edge
busy  output  1  high while a conversion is in progress (SHIFT or FINISH)
done  output  1  single-cycle pulse; bcd_out valid and newly updated
bcd_out  output  4*DIGITS  result; digit i occupies [4i+3:4i], digit 0 = units

Behaviour:
- Reset (reset_n low at a rising edge): state=IDLE, busy=0, done=0, bcd_out=0, shift register=0, bit counter=0. Reset overrides everything, including mid-conversion; the partial result is discarded and bcd_out is not updated.
- State machine (registered): IDLE, SHIFT, FINISH.
- IDLE: on an edge with start=1, latch bin_in into the binary shift register, clear the BCD scratch register (4*DIGITS bits), load counter=WIDTH, and go to SHIFT. With start=0, remain in IDLE.
- SHIFT, on each edge:
  - For every scratch digit >= 5, add 3 to that digit (4-bit add, no carry between digits).
  - Then shift {scratch, binary} left by one, with the binary MSB entering scratch bit 0.
  - Decrement the counter.
  - When the counter reaches 1 before the edge (last shift), go to FINISH.
  - Exactly WIDTH shift edges occur.
- FINISH: on the next edge, copy scratch to bcd_out, set done=1 and go to IDLE.
- done is high for exactly the one cycle following the FINISH edge. It is cleared on the following edge.
- busy is a registered output. It is 1 in the SHIFT and FINISH states and 0 in IDLE, including the cycle in which done=1.
- Latency: start is accepted at edge E0. SHIFT edges are E1..EWIDTH. The FINISH edge is EWIDTH+1, where bcd_out updates and done rises. For WIDTH=8, done is high in the cycle after edge E9.
- Back-to-back operation: the done=1 cycle is an IDLE cycle. A start asserted in that cycle is accepted, and the next conversion begins with no gap.
- start asserted while busy=1 is ignored and is not queued. bin_in changes while busy have no effect.
- start held high continuously causes a conversion to retrigger every WIDTH+2 cycles.
- bcd_out changes only at the FINISH edge or on reset. Between those events it holds its value.
- Arithmetic: every digit of bcd_out is always in the range 0..9 for legal parameters.

Test Plan:
1. Reset, then start=1 for one cycle with bin_in=8'd255 -> busy=1 for 9 cycles; done pulses for 1 cycle after edge E9; bcd_out=12'h255; busy=0 in the done cycle.
2. Conversions of bin_in=0, 9, 10, 99, 100, 128 -> bcd_out=12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h128 respectively; each done pulse is exactly one cycle wide.
3. Start a conversion with 200, then pulse start at cycle 3 with bin_in=7 -> the second start is ignored; the result is 12'h200; only one done pulse occurs.
4. Start with 8'd173, then drive reset_n=0 at cycle 4 -> at the next edge busy=0, done=0, bcd_out=0, state IDLE; no done pulse appears afterwards.
5. Convert 42, then assert start with bin_in=8'd250 in the done cycle -> the second conversion is accepted immediately; done pulses again 10 cycles later with bcd_out=12'h250; bcd_out holds 12'h042 in between.
6. Exhaustive sweep of bin_in over 0..255 with start tied high -> each done pulse is 10 cycles apart, and each bcd_out matches the decimal value of the latched input.
